l2_port_arbiter: RTL
====================

# l2_port_arbiter

Two-port round-robin arbiter that shares the single L2 data cache (28-bit line address, 128-bit line) between the L1 instruction-cache and L1 data-cache miss paths. It sits between the two L1 memory interfaces and the L2 processor-side interface. It latches one request at a time, forwards it to L2, and routes the L2 completion back to the owning requester. The downstream L2 sees exactly one request stream and never sees two concurrent requests.

## Interface
- ADDR_W, 28, line address width
- DATA_W, 128, line data width
- clk  in  1  clock, all state updates on rising edge
- proc_reset_n  in  1  synchronous, active-low reset
- i_read, i_write  in  1 each  I-side request strobes, level, held until i_ready
- i_addr  in  ADDR_W  I-side line address
- i_wdata  in  DATA_W  I-side write line
- i_rdata  out  DATA_W  I-side read line, valid only with i_ready
- i_ready  out  1  I-side completion, one-cycle pulse
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same as the i_ports, for the D side
- l2_read, l2_write  out  1 each  request to L2, registered
- l2_addr  out  ADDR_W  registered latched address
- l2_wdata  out  DATA_W  registered latched write data
- l2_rdata  in  DATA_W  L2 read line
- l2_ready  in  1  L2 completion, may be combinational in the same cycle as the request

## Operation
- Valid request per port: req = read XOR write. read and write both high, or both low, means no request.
- States: IDLE and BUSY. The grant owner register gnt is 0 for I and 1 for D. last is the port served most recently.
- IDLE, no req: stay in IDLE; l2_read, l2_write, l2_addr and l2_wdata are all 0.
- IDLE, one req: grant that port.
- IDLE, both req: grant the port not equal to last (round-robin).
- On grant:
  - latch the port's op, addr and wdata into the l2_* registers (wdata is latched only for a write; otherwise it is 0);
  - set gnt;
  - go to BUSY.
- BUSY: l2_* hold the latched values. The arbiter ignores the requester inputs, including any change on them.
- BUSY with l2_ready=1:
  - assert the granted port's ready combinationally in that cycle;
  - drive that port's rdata = l2_rdata;
  - set last = gnt;
  - clear l2_read, l2_write, l2_addr and l2_wdata at the edge;
  - go to IDLE.
- A non-granted port's ready is 0 and its rdata is 0 at all times. Both ready outputs are 0 in IDLE.
- A requester that drops its request while BUSY is still served to completion and still receives its ready pulse.
- The next arbitration is evaluated in the IDLE cycle after completion. The L1s see ready one cycle late, so the just-served port's request is already deasserted or replaced by its next request in that cycle. A replacement request, such as a dirty-writeback followed by a refill, is a legal new request.
- l2_ready seen while in IDLE is ignored.

## Timing
- Reset (proc_reset_n=0 at an edge):
  - state = IDLE, gnt = 0, last = I, so D wins the first tie;
  - l2_read, l2_write, l2_addr and l2_wdata are all 0;
  - i_ready, d_ready, i_rdata and d_rdata are 0.
- Reset mid-BUSY abandons the transaction: no ready pulse, and L2 outputs drop at that edge.
- Request sampled in IDLE at cycle t → l2_read or l2_write high from cycle t+1.
- L2 hit completing in cycle t+1 → requester ready in cycle t+1, so the arbiter adds 1 cycle over a direct L2 connection.
- l2_ready in cycle n → l2_* are 0 in cycle n+1 (IDLE). The earliest next grant is at edge n+1→n+2, so L2 has a minimum one-cycle idle gap between requests.
- Each ready pulse is exactly one cycle wide, with exactly one per grant.
- Throughput: at most one transaction per 2 cycles.

## Test plan
- Single I read, addr 0x000_0010, L2 returns 0xAAAA…AA with l2_ready in the first BUSY cycle:
  - l2_read high for 1 cycle with l2_addr=0x0000010;
  - i_ready is a 1-cycle pulse with i_rdata=0xAAAA…AA;
  - d_ready stays 0.
- Simultaneous I read 0x100 and D write 0x200 (wdata 0x55…55) right after reset:
  - D is granted first: l2_write with l2_addr=0x200 and l2_wdata=0x55…55;
  - then I is granted with l2_read at 0x100;
  - the two grants are separated by one IDLE cycle.
- Both ports request continuously for 8 transactions: grants alternate D, I, D, I…; no port receives two consecutive grants while the other is waiting.
- L2 holds l2_ready low for 5 BUSY cycles while the D request changes its addr from 0x300 to 0x3FF:
  - l2_addr stays 0x300 throughout;
  - d_ready pulses once in cycle 6.
- Invalid strobes d_read=d_write=1 together with i_read: only I is granted; D is never forwarded.
- Reset asserted in the second BUSY cycle:
  - the next cycle has all l2_* at 0 and no ready pulse;
  - after reset is released, the next tie grants D.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// ============================================================================
// Module   : l2_port_arbiter
// Brief    : Round-robin arbiter sharing one L2 port between I- and D-miss paths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_ready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic C_PORT_I = 1'b0;
    localparam logic C_PORT_D = 1'b1;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              l2_read_q, l2_read_d;
    logic              l2_write_q, l2_write_d;
    logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
    logic [DATA_W-1:0] l2_wdata_q, l2_wdata_d;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_pick_d;
    logic              w_done;
    logic              w_sel_read;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_i_req = i_read ^ i_write;
    assign w_d_req = d_read ^ d_write;

    // On a tie the port that was not served last wins.
    assign w_pick_d    = w_d_req && (!w_i_req || (last_q == C_PORT_I));
    assign w_sel_read  = w_pick_d ? d_read  : i_read;
    assign w_sel_write = w_pick_d ? d_write : i_write;
    assign w_sel_addr  = w_pick_d ? d_addr  : i_addr;
    assign w_sel_wdata = w_sel_write ? (w_pick_d ? d_wdata : i_wdata) : '0;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        l2_read_d  = l2_read_q;
        l2_write_d = l2_write_q;
        l2_addr_d  = l2_addr_q;
        l2_wdata_d = l2_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_i_req || w_d_req) begin
                    state_d    = ST_BUSY;
                    gnt_d      = w_pick_d;
                    l2_read_d  = w_sel_read;
                    l2_write_d = w_sel_write;
                    l2_addr_d  = w_sel_addr;
                    l2_wdata_d = w_sel_wdata;
                end
            end
            ST_BUSY: begin
                if (l2_ready) begin
                    state_d    = ST_IDLE;
                    last_d     = gnt_q;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    l2_addr_d  = '0;
                    l2_wdata_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= C_PORT_I;
            last_q     <= C_PORT_I;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            l2_addr_q  <= '0;
            l2_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            l2_read_q  <= l2_read_d;
            l2_write_q <= l2_write_d;
            l2_addr_q  <= l2_addr_d;
            l2_wdata_q <= l2_wdata_d;
        end
    end

    // A completion coinciding with reset is abandoned, so no ready escapes.
    assign w_done  = (state_q == ST_BUSY) && l2_ready && proc_reset_n;
    assign i_ready = w_done && (gnt_q == C_PORT_I);
    assign d_ready = w_done && (gnt_q == C_PORT_D);
    assign i_rdata = i_ready ? l2_rdata : '0;
    assign d_rdata = d_ready ? l2_rdata : '0;

    assign l2_read  = l2_read_q;
    assign l2_write = l2_write_q;
    assign l2_addr  = l2_addr_q;
    assign l2_wdata = l2_wdata_q;

endmodule

`default_nettype wire
